// File: rtl/sbox_share_sched.sv
// sbox_share_sched: round-robin issue scheduler for a two-share pipelined masked S-box.
// Tracks in-flight work with a LATENCY-deep tag line and routes each result to its requester.
// Optional feature macro: SBOX_SCHED_DUMMY_EN (dummy issues on idle randomness).
module sbox_share_sched #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned RAND_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [3:0]        req0_in0,
    input  logic [3:0]        req0_in1,
    input  logic [3:0]        req1_in0,
    input  logic [3:0]        req1_in1,
    input  logic [RAND_W-1:0] rnd_i,
    input  logic              rnd_valid,
    output logic              rnd_ack,
    output logic [3:0]        sb_in0,
    output logic [3:0]        sb_in1,
    output logic [RAND_W-1:0] sb_r,
    input  logic [3:0]        sb_out0,
    input  logic [3:0]        sb_out1,
    output logic              rsp0_valid,
    output logic [3:0]        rsp0_out0,
    output logic [3:0]        rsp0_out1,
    output logic              rsp1_valid,
    output logic [3:0]        rsp1_out0,
    output logic [3:0]        rsp1_out1,
    input  logic              flush,
    output logic              busy
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_ptr;
    logic               w_ptr_nxt;
    logic [LATENCY-1:0] r_tag_v;
    logic [LATENCY-1:0] r_tag_id;
`ifdef SBOX_SCHED_DUMMY_EN
    logic [LATENCY-1:0] r_tag_dm;
`endif
    logic               w_can_issue;
    logic               w_issue;
    logic               w_dummy;
    logic               w_gnt_id;
    logic               w_retire;

    // State, drain counter and round-robin pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ptr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Tag line: shifts every cycle, cleared when flush is sampled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
`ifdef SBOX_SCHED_DUMMY_EN
            r_tag_dm <= '0;
`endif
        end else if (flush) begin
            r_tag_v  <= '0;
            r_tag_id <= '0;
`ifdef SBOX_SCHED_DUMMY_EN
            r_tag_dm <= '0;
`endif
        end else begin
            r_tag_v  <= (r_tag_v << 1) | LATENCY'(w_issue | w_dummy);
            r_tag_id <= (r_tag_id << 1) | LATENCY'(w_gnt_id);
`ifdef SBOX_SCHED_DUMMY_EN
            r_tag_dm <= (r_tag_dm << 1) | LATENCY'(w_dummy);
`endif
        end
    end

    // Arbitration, issue datapath, next-state logic and result routing
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_issue     = 1'b0;
        w_dummy     = 1'b0;
        w_gnt_id    = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rnd_ack     = 1'b0;
        sb_in0      = 4'h0;
        sb_in1      = 4'h0;
        sb_r        = '0;
        rsp0_valid  = 1'b0;
        rsp0_out0   = 4'h0;
        rsp0_out1   = 4'h0;
        rsp1_valid  = 1'b0;
        rsp1_out0   = 4'h0;
        rsp1_out1   = 4'h0;
        busy        = (r_state != IDLE);

        // flush wins over issue; reset gating keeps every output low while rst_n is low
        w_can_issue = rst_n && !flush && rnd_valid && (r_state != DRAIN);

        if (w_can_issue && (req0_valid || req1_valid)) begin
            w_issue   = 1'b1;
            w_gnt_id  = (req0_valid && req1_valid) ? r_ptr : req1_valid;
            w_ptr_nxt = ~w_gnt_id;
            rnd_ack   = 1'b1;
            sb_r      = rnd_i;
            if (w_gnt_id) begin
                req1_ready = 1'b1;
                sb_in0     = req1_in0;
                sb_in1     = req1_in1;
            end else begin
                req0_ready = 1'b1;
                sb_in0     = req0_in0;
                sb_in1     = req0_in1;
            end
        end
`ifdef SBOX_SCHED_DUMMY_EN
        else if (w_can_issue) begin
            w_dummy = 1'b1;
            rnd_ack = 1'b1;
            sb_in0  = rnd_i[3:0];
            sb_in1  = rnd_i[7:4];
            sb_r    = rnd_i;
        end
`endif

        case (r_state)
            IDLE: begin
                if (flush) begin
                    w_state_nxt = DRAIN;
                    w_cnt_nxt   = CNT_W'(LATENCY - 1);
                end else if (w_issue) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    w_state_nxt = DRAIN;
                    w_cnt_nxt   = CNT_W'(LATENCY - 1);
                end else if (!w_issue && !w_dummy && (r_tag_v == '0)) begin
                    w_state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (flush) begin
                    w_cnt_nxt = CNT_W'(LATENCY - 1);
                end else if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // A result is delivered only to the requester named in its tag
        w_retire = r_tag_v[LATENCY-1] && (r_state != DRAIN);
`ifdef SBOX_SCHED_DUMMY_EN
        w_retire = w_retire && !r_tag_dm[LATENCY-1];
`endif
        if (w_retire) begin
            if (r_tag_id[LATENCY-1]) begin
                rsp1_valid = 1'b1;
                rsp1_out0  = sb_out0;
                rsp1_out1  = sb_out1;
            end else begin
                rsp0_valid = 1'b1;
                rsp0_out0  = sb_out0;
                rsp0_out1  = sb_out1;
            end
        end
    end

endmodule

// File: tb/tb_sbox_share_sched.sv
// Testbench for sbox_share_sched: directed scenarios plus randomized traffic, all checked
// against a cycle-level behavioural model. Emulates a PRESENT-style masked S-box pipeline.
module tb_sbox_share_sched;

    localparam int LAT = 4;
    localparam int RW  = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]    req0_in0, req0_in1, req1_in0, req1_in1;
    logic [RW-1:0] rnd_i;
    logic          rnd_valid, rnd_ack;
    logic [3:0]    sb_in0, sb_in1, sb_out0, sb_out1;
    logic [RW-1:0] sb_r;
    logic          rsp0_valid, rsp1_valid;
    logic [3:0]    rsp0_out0, rsp0_out1, rsp1_out0, rsp1_out1;
    logic          flush, busy;

    always #5 clk = ~clk;

    sbox_share_sched #(.LATENCY(LAT), .RAND_W(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_in0(req0_in0), .req0_in1(req0_in1),
        .req1_in0(req1_in0), .req1_in1(req1_in1),
        .rnd_i(rnd_i), .rnd_valid(rnd_valid), .rnd_ack(rnd_ack),
        .sb_in0(sb_in0), .sb_in1(sb_in1), .sb_r(sb_r),
        .sb_out0(sb_out0), .sb_out1(sb_out1),
        .rsp0_valid(rsp0_valid), .rsp0_out0(rsp0_out0), .rsp0_out1(rsp0_out1),
        .rsp1_valid(rsp1_valid), .rsp1_out0(rsp1_out0), .rsp1_out1(rsp1_out1),
        .flush(flush), .busy(busy)
    );

    function automatic logic [3:0] sbox_f(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'h21748FE3DA09B65C;
        return tbl[4*x +: 4];
    endfunction

    // Masked S-box emulation: result = S(in0^in1) split with mask r[3:0]
    logic [11:0] sb_pipe [LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) sb_pipe[i] <= sb_pipe[i-1];
        sb_pipe[0] <= {sb_in0, sb_in1, sb_r[3:0]};
    end
    assign sb_out1 = sb_pipe[LAT-1][3:0];
    assign sb_out0 = sbox_f(sb_pipe[LAT-1][11:8] ^ sb_pipe[LAT-1][7:4]) ^ sb_pipe[LAT-1][3:0];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model state
    typedef struct {
        int         due;
        logic       id;
        logic [3:0] val;
    } exp_t;
    exp_t q[$];
    logic m_ptr = 1'b0;
    bit   m_run = 1'b0;
    int   m_last_any = -1000;
    int   m_drain_until = -1;

    task automatic model_step();
        bit         draining, issue, dummy, gid, e_v0, e_v1;
        logic [3:0] e_in0, e_in1, v_in, v_rsp;
        logic [RW-1:0] e_r;
        if (!rst_n) begin
            check_eq("rst_ctl", 64'({req0_ready, req1_ready, rnd_ack, busy, rsp0_valid, rsp1_valid}), 64'd0);
            check_eq("rst_sb", 64'({sb_in0, sb_in1}), 64'd0);
            check_eq("rst_sbr", 64'(sb_r), 64'd0);
            check_eq("rst_rsp", 64'({rsp0_out0, rsp0_out1, rsp1_out0, rsp1_out1}), 64'd0);
            q.delete();
            m_ptr = 1'b0; m_run = 1'b0; m_last_any = -1000; m_drain_until = -1;
        end else begin
            draining = (cyc <= m_drain_until);
            issue    = !flush && rnd_valid && !draining && (req0_valid || req1_valid);
            dummy    = 1'b0;
`ifdef SBOX_SCHED_DUMMY_EN
            dummy    = !flush && rnd_valid && !draining && !req0_valid && !req1_valid;
`endif
            gid   = (req0_valid && req1_valid) ? m_ptr : req1_valid;
            e_in0 = 4'h0; e_in1 = 4'h0; e_r = '0;
            if (issue) begin
                e_in0 = gid ? req1_in0 : req0_in0;
                e_in1 = gid ? req1_in1 : req0_in1;
                e_r   = rnd_i;
            end else if (dummy) begin
                e_in0 = rnd_i[3:0];
                e_in1 = rnd_i[7:4];
                e_r   = rnd_i;
            end
            v_in  = e_in0 ^ e_in1;
            e_v0  = (q.size() > 0) && (q[0].due == cyc) && !q[0].id;
            e_v1  = (q.size() > 0) && (q[0].due == cyc) && q[0].id;
            v_rsp = 4'h0;
            if (e_v0 || e_v1) begin
                v_rsp = q[0].val;
                void'(q.pop_front());
            end

            check_eq("req0_ready", 64'(req0_ready), 64'(issue && !gid));
            check_eq("req1_ready", 64'(req1_ready), 64'(issue && gid));
            check_eq("rnd_ack", 64'(rnd_ack), 64'(issue || dummy));
            check_eq("sb_in", 64'({sb_in0, sb_in1}), 64'({e_in0, e_in1}));
            check_eq("sb_r", 64'(sb_r), 64'(e_r));
            check_eq("busy", 64'(busy), 64'(m_run || draining));
            check_eq("rsp0_valid", 64'(rsp0_valid), 64'(e_v0));
            check_eq("rsp1_valid", 64'(rsp1_valid), 64'(e_v1));
            if (e_v0) begin
                check_eq("rsp0_data", 64'(rsp0_out0 ^ rsp0_out1), 64'(sbox_f(v_rsp)));
                check_eq("rsp0_share", 64'(rsp0_out0), 64'(sb_out0));
            end else begin
                check_eq("rsp0_zero", 64'({rsp0_out0, rsp0_out1}), 64'd0);
            end
            if (e_v1) begin
                check_eq("rsp1_data", 64'(rsp1_out0 ^ rsp1_out1), 64'(sbox_f(v_rsp)));
                check_eq("rsp1_share", 64'(rsp1_out0), 64'(sb_out0));
            end else begin
                check_eq("rsp1_zero", 64'({rsp1_out0, rsp1_out1}), 64'd0);
            end

            if (flush) begin
                m_run = 1'b0;
                m_drain_until = cyc + LAT;
                m_last_any = -1000;
                q.delete();
            end else if (!draining) begin
                m_run = issue || (m_run && (dummy || (cyc - m_last_any <= LAT)));
            end
            if (issue) begin
                q.push_back('{due: cyc + LAT, id: gid, val: v_in});
                m_ptr = ~gid;
            end
            if (issue || dummy) m_last_any = cyc;
        end
    endtask

    task automatic run_cycle(input logic rst, input logic v0, input logic v1, input logic rv,
                             input logic fl, input logic [3:0] a0, input logic [3:0] a1,
                             input logic [3:0] b0, input logic [3:0] b1);
        rst_n      = ~rst;
        req0_valid = v0;  req1_valid = v1;
        req0_in0   = a0;  req0_in1   = a1;
        req1_in0   = b0;  req1_in1   = b1;
        rnd_valid  = rv;
        rnd_i      = {$urandom, $urandom};
        flush      = fl;
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cyc_rand(input logic rst, input logic v0, input logic v1, input logic rv,
                            input logic fl);
        run_cycle(rst, v0, v1, rv, fl, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    endtask

    initial begin
        // reset with live-looking inputs
        repeat (3) cyc_rand(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        // single request, shares 3/3 -> S(0) = 0xC after LAT cycles
        run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 4'h3, 4'h0, 4'h0);
        repeat (7) cyc_rand(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // both requesters contending for 6 cycles
        repeat (6) cyc_rand(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (7) cyc_rand(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // no randomness -> no grant, then grant on first fresh word
        repeat (3) cyc_rand(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc_rand(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (7) cyc_rand(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // two issues, flush two cycles later, then a fresh request
        repeat (2) cyc_rand(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc_rand(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc_rand(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (6) cyc_rand(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc_rand(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (7) cyc_rand(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // reset with three results in flight
        repeat (3) cyc_rand(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) cyc_rand(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (8) cyc_rand(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SBOX_SCHED_DUMMY_EN
        // idle with randomness available -> dummy issues only
        repeat (10) cyc_rand(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (7) cyc_rand(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        // randomized traffic with occasional flush and reset
        for (int n = 0; n < 800; n++) begin
            cyc_rand(1'($urandom_range(0, 99) == 0),
                     1'($urandom_range(0, 9) < 6),
                     1'($urandom_range(0, 9) < 5),
                     1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 29) == 0));
        end
        repeat (8) cyc_rand(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
